// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : comp_pkg
//  Purpose : Event codes and arbiter state encoding shared by comp_arbiter.
//            The LOCK state exists only when COMP_LOCKOUT_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
package comp_pkg;

  localparam logic [1:0] CODE_A    = 2'b10;
  localparam logic [1:0] CODE_B    = 2'b01;
  localparam logic [1:0] CODE_TIE  = 2'b00;
  localparam logic [1:0] CODE_IDLE = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_A = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
`ifdef COMP_LOCKOUT_EN
  localparam logic [2:0] S_LOCK   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_WAIT_A = S_WAIT_A,
    ST_WAIT_B = S_WAIT_B,
    ST_EMIT   = S_EMIT,
    ST_LOCK   = S_LOCK
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_WAIT_A = S_WAIT_A,
    ST_WAIT_B = S_WAIT_B,
    ST_EMIT   = S_EMIT
  } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/comp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : comp_arbiter_if
//  Purpose : Raw button inputs and classified event outputs of comp_arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface comp_arbiter_if;
  logic       btn_a;
  logic       btn_b;
  logic [1:0] comp_out;
  logic       comp_valid;
  logic       busy;

  modport master (output btn_a, output btn_b,
                  input  comp_out, input comp_valid, input busy);
  modport slave  (input  btn_a, input btn_b,
                  output comp_out, output comp_valid, output busy);
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : btn_debounce
//  Purpose : Two-flop synchronizer, counter debounce and registered
//            rising-edge event pulse for one raw button input.
//  Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_btn,
  output logic      o_evt
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_evt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_evt      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      // The stable level only follows after DEB_CYCLES disagreeing samples in a row.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      r_stable_d <= r_stable;
      r_evt      <= r_stable & ~r_stable_d;
    end
  end

  assign o_evt = r_evt;

endmodule
`default_nettype wire

// File: rtl/comp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : comp_arbiter
//  Purpose : Debounces two channels and classifies each press as A-first,
//            B-first or tie within a WINDOW-cycle coincidence window.
//            Optional macro COMP_LOCKOUT_EN adds a post-emit lockout.
//  Rev     : 1.0  initial release
// ============================================================================
module comp_arbiter #(
  parameter int DEB_CYCLES     = 16,
  parameter int WINDOW         = 4,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  comp_arbiter_if.slave bus
);

  import comp_pkg::*;

  if (DEB_CYCLES < 2 || WINDOW < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("comp_arbiter: illegal parameter value");
  end

  localparam int WW = $clog2(WINDOW) + 1;
  localparam logic [WW-1:0] c_WIN_LAST = WW'(WINDOW - 1);
  localparam logic [WW-1:0] c_WIN_ONE  = WW'(1);

  logic w_evt_a;
  logic w_evt_b;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .i_btn (bus.btn_a),
    .o_evt (w_evt_a)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .i_btn (bus.btn_b),
    .o_evt (w_evt_b)
  );

  state_t        r_state;
  logic [WW-1:0] r_win;
  logic [1:0]    r_code;
  logic          r_valid;
  logic          r_busy;

`ifdef COMP_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [LW-1:0] c_LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [LW-1:0] c_LOCK_ONE  = LW'(1);
  logic [LW-1:0] r_lock;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_code  <= CODE_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef COMP_LOCKOUT_EN
      r_lock  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_evt_a && w_evt_b) begin
            r_state <= ST_EMIT;
            r_code  <= CODE_TIE;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_evt_a) begin
            r_state <= ST_WAIT_B;
            r_win   <= '0;
            r_busy  <= 1'b1;
          end else if (w_evt_b) begin
            r_state <= ST_WAIT_A;
            r_win   <= '0;
            r_busy  <= 1'b1;
          end
        end
        // The partner's evt wins over the timeout on the final window cycle.
        ST_WAIT_B: begin
          if (w_evt_b) begin
            r_state <= ST_EMIT;
            r_code  <= CODE_TIE;
            r_valid <= 1'b1;
          end else if (r_win == c_WIN_LAST) begin
            r_state <= ST_EMIT;
            r_code  <= CODE_A;
            r_valid <= 1'b1;
          end else begin
            r_win <= r_win + c_WIN_ONE;
          end
        end
        ST_WAIT_A: begin
          if (w_evt_a) begin
            r_state <= ST_EMIT;
            r_code  <= CODE_TIE;
            r_valid <= 1'b1;
          end else if (r_win == c_WIN_LAST) begin
            r_state <= ST_EMIT;
            r_code  <= CODE_B;
            r_valid <= 1'b1;
          end else begin
            r_win <= r_win + c_WIN_ONE;
          end
        end
        ST_EMIT: begin
          r_code  <= CODE_IDLE;
          r_valid <= 1'b0;
`ifdef COMP_LOCKOUT_EN
          r_state <= ST_LOCK;
          r_lock  <= '0;
`else
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`endif
        end
`ifdef COMP_LOCKOUT_EN
        ST_LOCK: begin
          if (r_lock == c_LOCK_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lock <= r_lock + c_LOCK_ONE;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_code  <= CODE_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.comp_out   = r_code;
  assign bus.comp_valid = r_valid;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_comp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_comp_arbiter
//  Purpose : Directed and random button stimulus against a timing model of
//            comp_arbiter, with a queued scoreboard checked at each output.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_comp_arbiter;

  import comp_pkg::*;

  localparam int DEB   = 4;
  localparam int WIN   = 4;
  localparam int LOCKC = 8;
`ifdef COMP_LOCKOUT_EN
  localparam int LOCK_LEN = LOCKC;
`else
  localparam int LOCK_LEN = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  comp_arbiter_if bus();

  comp_arbiter #(
    .DEB_CYCLES     (DEB),
    .WINDOW         (WIN),
    .LOCKOUT_CYCLES (LOCKC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    int         en;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: edge index, raw-input history, debounce run lengths.
  int edge_n = -1;
  bit dly[2][2];
  bit stable[2];
  int run[2];
  bit ep[2][2];
  int pend      = 0;     // 0 none, 1 A seen waiting for B, 2 B seen waiting for A
  int t0        = 0;
  int free_from = 0;     // first edge at which the arbiter accepts events again
  bit exp_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic emit(input logic [1:0] c);
    q.push_back('{code: c, en: edge_n});
    pend      = 0;
    free_from = edge_n + 2 + LOCK_LEN;
  endtask

  task automatic model_step(input bit ra, input bit rb, input bit rs);
    bit btn[2];
    bit seen[2];
    bit s;
    bit other;
    edge_n++;
    btn[0] = ra;
    btn[1] = rb;
    if (rs) begin
      for (int c = 0; c < 2; c++) begin
        dly[c][0] = 0; dly[c][1] = 0; ep[c][0] = 0; ep[c][1] = 0;
        stable[c] = 0; run[c] = 0;
      end
      pend      = 0;
      free_from = 0;
      exp_busy  = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      s         = dly[c][1];
      dly[c][1] = dly[c][0];
      dly[c][0] = btn[c];
      seen[c]   = ep[c][1];
      ep[c][1]  = ep[c][0];
      ep[c][0]  = 0;
      if (s != stable[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          stable[c] = s;
          run[c]    = 0;
          ep[c][0]  = s;
        end
      end else begin
        run[c] = 0;
      end
    end
    if (edge_n >= free_from) begin
      if (pend == 0) begin
        if (seen[0] && seen[1]) emit(CODE_TIE);
        else if (seen[0]) begin pend = 1; t0 = edge_n; end
        else if (seen[1]) begin pend = 2; t0 = edge_n; end
      end else begin
        other = (pend == 1) ? seen[1] : seen[0];
        if (other) emit(CODE_TIE);
        else if (edge_n - t0 == WIN) emit((pend == 1) ? CODE_A : CODE_B);
      end
    end
    exp_busy = (pend != 0) || (edge_n < free_from - 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(bus.btn_a, bus.btn_b, reset);
    end
  end

  // Monitor: outputs are sampled on the falling edge, after the model has stepped.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
      if (q.size() > 0 && q[0].en < edge_n) begin
        e = q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missed_valid: code %b expected after edge %0d, no comp_valid observed by edge %0d",
                 e.code, e.en, edge_n);
      end
      if (bus.comp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid at edge %0d: got code %b, expected no event",
                   edge_n, bus.comp_out);
        end else begin
          e = q.pop_front();
          check("code", {30'b0, bus.comp_out}, {30'b0, e.code});
          check("emit_edge", edge_n, e.en);
        end
      end else begin
        check("valid_low", {31'b0, bus.comp_valid}, 32'd0);
        check("idle_code", {30'b0, bus.comp_out}, {30'b0, CODE_IDLE});
      end
    end
  end

  task automatic drive(input bit a, input bit b, input int n);
    bus.btn_a = a;
    bus.btn_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.btn_a = 1'b1;
    bus.btn_b = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 30);
    // A alone, both together, B-then-A at lags 3, 5 and the boundary lag 4.
    drive(1, 0, 20); drive(0, 0, 30);
    drive(1, 1, 20); drive(0, 0, 30);
    drive(0, 1, 3);  drive(1, 1, 20); drive(0, 0, 30);
    drive(0, 1, 5);  drive(1, 1, 20); drive(0, 0, 30);
    drive(0, 1, 4);  drive(1, 1, 20); drive(0, 0, 30);
    // Short pulse below debounce length.
    drive(1, 0, 2);  drive(0, 0, 30);
    // Reset while waiting for B.
    drive(1, 0, 9);  bus.btn_a = 1'b0; reset_pulse(); drive(0, 0, 30);
    // B press whose evt lands shortly after an A emit.
    drive(1, 0, 12); drive(1, 1, 20); drive(0, 0, 40);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse();
      else drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    drive(0, 0, 40);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
